mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, meaning cycles the select is held before Y is sampled (legal 0..15).
REQ-002 Parameter CONT, default 0, meaning 1 restarts a new scan automatically after each handshake.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request one scan; sampled only in IDLE.
REQ-006 s0  output  1  mux select MSB, driven to the 8:1 mux s0 input.
REQ-007 s1  output  1  mux select middle bit, driven to the mux s1 input.
REQ-008 s2  output  1  mux select LSB, driven to the mux s2 input.
REQ-009 Y  input  1  selected mux output, consumed by this block.
REQ-010 busy  output  1  high while a scan is in progress (SETTLE or SAMPLE).
REQ-011 data_out  output  8  captured word; bit i is the value of Y with select {s0,s1,s2}=i.
REQ-012 data_valid  output  1  data_out is valid and held until accepted.
REQ-013 out_ready  input  1  consumer accepts data_out when high with data_valid.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE; all state, index, settle counter, shadow and outputs are registered.
REQ-015 3-bit channel index idx drives {s0,s1,s2}=idx directly; the select changes only on the edge leaving SAMPLE or entering a scan.
REQ-016 IDLE with start=1: next state SETTLE (or SAMPLE if SETTLE=0), idx=0, shadow cleared; IDLE with start=0: hold.
REQ-017 SETTLE lasts exactly SETTLE cycles, then goes to SAMPLE; idx is unchanged throughout.
REQ-018 SAMPLE lasts one cycle; at its closing edge shadow[idx] takes Y.
REQ-019 SAMPLE with idx<7: idx increments by 1, next state SETTLE (or SAMPLE if SETTLE=0).
REQ-020 SAMPLE with idx=7: data_out takes the complete word including the current Y, data_valid goes to 1, idx wraps to 0, next state DONE.
REQ-021 Per-channel time is SETTLE+1 cycles; data_valid rises exactly 8*(SETTLE+1) edges after the edge that accepts start (16 at SETTLE=1, 8 at SETTLE=0).
REQ-022 DONE holds data_out, data_valid=1 and select 000 while out_ready=0; start is ignored in DONE.
REQ-023 DONE with out_ready=1: data_valid clears on that edge; next state IDLE if CONT=0, or a new scan at idx=0 if CONT=1 (no start required).
REQ-024 data_out keeps its last captured value after the handshake until the next scan completes.
REQ-025 start asserted while busy or in DONE has no effect and is not queued.
REQ-026 busy is 1 exactly in SETTLE and SAMPLE; busy and data_valid are never both 1.
REQ-027 out_ready while data_valid=0 has no effect.

Reset
REQ-028 rst=1 at an edge forces IDLE, idx=0 ({s0,s1,s2}=000), settle counter 0, shadow 0, data_out 8'h00, data_valid 0, busy 0.
REQ-029 rst has priority over start, out_ready and any in-flight scan; an interrupted scan is discarded and never produces data_valid.
REQ-030 The first start is accepted on the first edge with rst=0 and start=1.

Verification
REQ-031 Mux model D=8'hA5, SETTLE=1, start pulse, out_ready=1 -> selects step 000..111, two cycles each; data_valid 16 edges after start; data_out=8'hA5; back to IDLE.
REQ-032 One-hot D=8'h01,8'h02,...,8'h80 over eight scans -> data_out equals D each time (bit mapping and wrap check).
REQ-033 SETTLE=0, D=8'h3C -> select changes every cycle; data_valid 8 edges after start; data_out=8'h3C.
REQ-034 out_ready held 0 for 5 cycles after data_valid -> data_out/data_valid stable, select 000, start pulses ignored; accepted on the first out_ready=1 edge.
REQ-035 rst asserted while idx=4 -> next cycle IDLE, select 000, busy 0, data_out 8'h00, no data_valid; a new start then completes normally.
REQ-036 CONT=1, out_ready=1, D changed 8'hFF->8'h00 between scans -> back-to-back scans without start; consecutive words 8'hFF then 8'h00.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans an external 8:1 mux channel by channel and captures its output as one byte
// Each channel is held for SETTLE cycles and then sampled for one cycle; the finished word is held until accepted.
module mux_scan_ctrl #(
   parameter int unsigned SETTLE = 1,
   parameter bit          CONT   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   input  logic       Y,
   output logic       busy,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   // With no settle time a channel goes straight to its sample cycle.
   localparam state_t     FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [3:0] LAST_CNT = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shadow_q, shadow_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_valid_q, data_valid_d;
   logic       busy_q, busy_d;
   logic [7:0] captured;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      shadow_d      = shadow_q;
      data_out_d    = data_out_q;
      data_valid_d  = data_valid_q;
      captured      = shadow_q;
      captured[idx_q] = Y;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = FIRST_ST;
               idx_d    = 3'd0;
               cnt_d    = 4'd0;
               shadow_d = 8'h00;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_SAMPLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            shadow_d = captured;
            if (idx_q == 3'd7) begin
               data_out_d   = captured;
               data_valid_d = 1'b1;
               idx_d        = 3'd0;
               state_d      = ST_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               cnt_d   = 4'd0;
               state_d = FIRST_ST;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               data_valid_d = 1'b0;
               if (CONT) begin
                  state_d  = FIRST_ST;
                  idx_d    = 3'd0;
                  cnt_d    = 4'd0;
                  shadow_d = 8'h00;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 3'd0;
         cnt_q        <= 4'd0;
         shadow_q     <= 8'h00;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign s0         = idx_q[2];
   assign s1         = idx_q[1];
   assign s2         = idx_q[0];
   assign busy       = busy_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed bench for mux_scan_ctrl against behavioural 8:1 mux models
module tb_mux_scan_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // a: SETTLE=1 one-shot, b: SETTLE=0, c: SETTLE=1 continuous
   logic       start_a, s0_a, s1_a, s2_a, y_a, busy_a, dv_a, rdy_a;
   logic [7:0] do_a, d_a;
   logic       start_b, s0_b, s1_b, s2_b, y_b, busy_b, dv_b, rdy_b;
   logic [7:0] do_b, d_b;
   logic       start_c, s0_c, s1_c, s2_c, y_c, busy_c, dv_c, rdy_c;
   logic [7:0] do_c, d_c;

   assign y_a = d_a[{s0_a, s1_a, s2_a}];
   assign y_b = d_b[{s0_b, s1_b, s2_b}];
   assign y_c = d_c[{s0_c, s1_c, s2_c}];

   mux_scan_ctrl #(.SETTLE(1), .CONT(1'b0)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .s0(s0_a), .s1(s1_a), .s2(s2_a), .Y(y_a),
      .busy(busy_a), .data_out(do_a), .data_valid(dv_a), .out_ready(rdy_a));
   mux_scan_ctrl #(.SETTLE(0), .CONT(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .s0(s0_b), .s1(s1_b), .s2(s2_b), .Y(y_b),
      .busy(busy_b), .data_out(do_b), .data_valid(dv_b), .out_ready(rdy_b));
   mux_scan_ctrl #(.SETTLE(1), .CONT(1'b1)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .s0(s0_c), .s1(s1_c), .s2(s2_c), .Y(y_c),
      .busy(busy_c), .data_out(do_c), .data_valid(dv_c), .out_ready(rdy_c));

   // Pulses start on dut a and returns the number of edges after the accepting edge until data_valid.
   task automatic scan_a(output int edges);
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      edges = 0;
      while (dv_a !== 1'b1 && edges < 100) begin
         @(negedge clk); edges++;
      end
   endtask

   task automatic test_reset();
      n_cmp++; if ({s0_a, s1_a, s2_a, busy_a, dv_a} !== 5'b0 || do_a !== 8'h00) begin
         n_err++; $display("FAIL reset_a sel/busy/dv=%b data=%h expected 00000/00", {s0_a, s1_a, s2_a, busy_a, dv_a}, do_a);
      end
      n_cmp++; if ({s0_b, s1_b, s2_b, busy_b, dv_b} !== 5'b0 || do_b !== 8'h00) begin
         n_err++; $display("FAIL reset_b sel/busy/dv=%b data=%h expected 00000/00", {s0_b, s1_b, s2_b, busy_b, dv_b}, do_b);
      end
      n_cmp++; if ({s0_c, s1_c, s2_c, busy_c, dv_c} !== 5'b0 || do_c !== 8'h00) begin
         n_err++; $display("FAIL reset_c sel/busy/dv=%b data=%h expected 00000/00", {s0_c, s1_c, s2_c, busy_c, dv_c}, do_c);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int e;
      d_a = 8'hA5; rdy_a = 1'b1;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      e = 0;
      while (dv_a !== 1'b1 && e < 100) begin
         n_cmp++; if ({s0_a, s1_a, s2_a} !== 3'(e / 2) || busy_a !== 1'b1) begin
            n_err++; $display("FAIL basic_sel edge=%0d sel=%b busy=%b expected sel=%b busy=1", e, {s0_a, s1_a, s2_a}, busy_a, 3'(e / 2));
         end
         @(negedge clk); e++;
      end
      n_cmp++; if (e !== 16) begin n_err++; $display("FAIL basic_latency got=%0d expected=16", e); end
      n_cmp++; if (do_a !== 8'hA5 || busy_a !== 1'b0) begin
         n_err++; $display("FAIL basic_data data=%h busy=%b expected a5/0", do_a, busy_a);
      end
      @(negedge clk);
      n_cmp++; if (dv_a !== 1'b0 || busy_a !== 1'b0 || do_a !== 8'hA5) begin
         n_err++; $display("FAIL basic_idle dv=%b busy=%b data=%h expected 0/0/a5", dv_a, busy_a, do_a);
      end
   endtask

   task automatic test_onehot();
      int e;
      rdy_a = 1'b1;
      for (int k = 0; k < 8; k++) begin
         d_a = 8'h01 << k;
         scan_a(e);
         n_cmp++; if (e !== 16 || do_a !== d_a) begin
            n_err++; $display("FAIL onehot k=%0d data=%h edges=%0d expected %h/16", k, do_a, e, d_a);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_settle0();
      int e;
      d_b = 8'h3C; rdy_b = 1'b1;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      e = 0;
      while (dv_b !== 1'b1 && e < 100) begin
         n_cmp++; if ({s0_b, s1_b, s2_b} !== 3'(e) || busy_b !== 1'b1) begin
            n_err++; $display("FAIL settle0_sel edge=%0d sel=%b busy=%b expected sel=%b busy=1", e, {s0_b, s1_b, s2_b}, busy_b, 3'(e));
         end
         @(negedge clk); e++;
      end
      n_cmp++; if (e !== 8 || do_b !== 8'h3C) begin
         n_err++; $display("FAIL settle0_data data=%h edges=%0d expected 3c/8", do_b, e);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int e;
      d_a = 8'h5A; rdy_a = 1'b0;
      scan_a(e);
      n_cmp++; if (e !== 16) begin n_err++; $display("FAIL bp_latency got=%0d expected=16", e); end
      for (int i = 0; i < 5; i++) begin
         start_a = (i % 2 == 0);
         @(negedge clk);
         n_cmp++; if (dv_a !== 1'b1 || do_a !== 8'h5A || {s0_a, s1_a, s2_a} !== 3'b000 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL bp_hold cyc=%0d dv=%b data=%h sel=%b busy=%b expected 1/5a/000/0", i, dv_a, do_a, {s0_a, s1_a, s2_a}, busy_a);
         end
      end
      start_a = 1'b0; rdy_a = 1'b1;
      @(negedge clk);
      n_cmp++; if (dv_a !== 1'b0 || busy_a !== 1'b0) begin
         n_err++; $display("FAIL bp_accept dv=%b busy=%b expected 0/0", dv_a, busy_a);
      end
      @(negedge clk);
      n_cmp++; if (busy_a !== 1'b0 || dv_a !== 1'b0 || do_a !== 8'h5A) begin
         n_err++; $display("FAIL bp_not_queued busy=%b dv=%b data=%h expected 0/0/5a", busy_a, dv_a, do_a);
      end
   endtask

   task automatic test_reset_midscan();
      int e;
      bit seen_dv;
      d_a = 8'hFF; rdy_a = 1'b1;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      e = 0;
      while ({s0_a, s1_a, s2_a} !== 3'd4 && e < 100) begin
         @(negedge clk); e++;
      end
      n_cmp++; if (e !== 8) begin n_err++; $display("FAIL rst_reach_idx4 got=%0d expected=8", e); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if ({s0_a, s1_a, s2_a} !== 3'b000 || busy_a !== 1'b0 || dv_a !== 1'b0 || do_a !== 8'h00) begin
         n_err++; $display("FAIL rst_mid sel=%b busy=%b dv=%b data=%h expected 000/0/0/00", {s0_a, s1_a, s2_a}, busy_a, dv_a, do_a);
      end
      seen_dv = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dv_a === 1'b1 || busy_a === 1'b1) seen_dv = 1'b1;
      end
      n_cmp++; if (seen_dv !== 1'b0) begin n_err++; $display("FAIL rst_discard activity=%b expected 0", seen_dv); end
      d_a = 8'hC3;
      scan_a(e);
      n_cmp++; if (e !== 16 || do_a !== 8'hC3) begin
         n_err++; $display("FAIL rst_restart data=%h edges=%0d expected c3/16", do_a, e);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int e;
      d_c = 8'hFF; rdy_c = 1'b1;
      @(negedge clk); start_c = 1'b1;
      @(negedge clk); start_c = 1'b0;
      e = 0;
      while (dv_c !== 1'b1 && e < 100) begin
         @(negedge clk); e++;
      end
      n_cmp++; if (e !== 16 || do_c !== 8'hFF) begin
         n_err++; $display("FAIL b2b_first data=%h edges=%0d expected ff/16", do_c, e);
      end
      d_c = 8'h00;
      @(negedge clk);
      n_cmp++; if (dv_c !== 1'b0 || busy_c !== 1'b1 || do_c !== 8'hFF) begin
         n_err++; $display("FAIL b2b_restart dv=%b busy=%b data=%h expected 0/1/ff", dv_c, busy_c, do_c);
      end
      e = 0;
      while (dv_c !== 1'b1 && e < 100) begin
         @(negedge clk); e++;
      end
      n_cmp++; if (e !== 16 || do_c !== 8'h00) begin
         n_err++; $display("FAIL b2b_second data=%h edges=%0d expected 00/16", do_c, e);
      end
      rdy_c = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0; rdy_a = 1'b0; d_a = 8'h00;
      start_b = 1'b0; rdy_b = 1'b0; d_b = 8'h00;
      start_c = 1'b0; rdy_c = 1'b0; d_c = 8'h00;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_onehot();
      test_settle0();
      test_backpressure();
      test_reset_midscan();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
